// File: rtl/timer_ctrl_master.sv
// timer_ctrl_master: Avalon-MM initiator that programs the interval timer and services its timeouts.
//   cfg_period/cfg_start/cfg_stop : start a continuous run with a new period, or stop it
//   busy/tick/tick_count          : run status, one pulse per serviced timeout, timeouts since start
//   m_*                           : registered master port driving the timer's s1 slave
//   m_readdata/irq_in             : timer readdata (one-cycle latency) and timeout interrupt
//   Optional macro TIMER_CTRL_SNAP_EN adds snap_value/snap_valid: after each tick the
//   timer counter is snapshotted and read back.
module timer_ctrl_master #(
  parameter int TICK_W    = 16,
  parameter int MAX_TICKS = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       cfg_period,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  output logic              busy,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
`ifdef TIMER_CTRL_SNAP_EN
  output logic [31:0]       snap_value,
  output logic              snap_valid,
`endif
  output logic [2:0]        m_address,
  output logic              m_chipselect,
  output logic              m_write_n,
  output logic [15:0]       m_writedata,
  input  logic [15:0]       m_readdata,
  input  logic              irq_in
);
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, WR_STOP, WR_CLR2,
    SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_DONE
  } state_t;
  state_t state, nxt;
  logic [31:0] period, per_in;
  logic [TICK_W-1:0] cnt_inc;
  logic stop_pend, hit_max;
  logic [2:0] addr_d;
  logic cs_d, wn_d;
  logic [15:0] wd_d;
  assign per_in  = (cfg_period == 32'd0) ? 32'd1 : cfg_period;
  assign cnt_inc = tick_count + TICK_W'(1);
  assign hit_max = (MAX_TICKS != 0) && (cnt_inc == TICK_W'(MAX_TICKS));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = cfg_start ? WR_PL : IDLE;
      WR_PL:     nxt = WR_PH;
      WR_PH:     nxt = WR_CTRL;
      WR_CTRL:   nxt = RUN;
      RUN:       nxt = (stop_pend || cfg_stop) ? WR_STOP : irq_in ? CLR_ST : RUN;
`ifdef TIMER_CTRL_SNAP_EN
      CLR_ST:    nxt = SNAP_WR;
      SNAP_WR:   nxt = SNAP_RDL;
      SNAP_RDL:  nxt = SNAP_RDH;
      SNAP_RDH:  nxt = SNAP_DONE;
      SNAP_DONE: nxt = RUN;
`else
      CLR_ST:    nxt = RUN;
`endif
      WR_STOP:   nxt = WR_CLR2;
      WR_CLR2:   nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  // Bus outputs are registered, so they are decoded from the state being entered.
  // WR_PL is only entered from IDLE, where period is not yet latched.
  always_comb begin
    cs_d   = 1'b1;
    wn_d   = 1'b0;
    addr_d = 3'd0;
    wd_d   = 16'd0;
    case (nxt)
      WR_PL:     begin addr_d = 3'd2; wd_d = per_in[15:0]; end
      WR_PH:     begin addr_d = 3'd3; wd_d = period[31:16]; end
      WR_CTRL:   begin addr_d = 3'd1; wd_d = 16'h0007; end
      WR_STOP:   begin addr_d = 3'd1; wd_d = 16'h0008; end
      CLR_ST, WR_CLR2: addr_d = 3'd0;
`ifdef TIMER_CTRL_SNAP_EN
      SNAP_WR:   addr_d = 3'd4;
      SNAP_RDL:  begin addr_d = 3'd4; wn_d = 1'b1; end
      SNAP_RDH, SNAP_DONE: begin addr_d = 3'd5; wn_d = 1'b1; end
`endif
      default:   begin cs_d = 1'b0; wn_d = 1'b1; end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_address    <= '0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_writedata  <= '0;
      busy         <= 1'b0;
      tick         <= 1'b0;
      tick_count   <= '0;
      period       <= '0;
      stop_pend    <= 1'b0;
    end else begin
      m_address    <= addr_d;
      m_chipselect <= cs_d;
      m_write_n    <= wn_d;
      m_writedata  <= wd_d;
      busy         <= nxt != IDLE;
      tick         <= nxt == CLR_ST;
      if (state == IDLE && cfg_start) begin
        period     <= per_in;
        tick_count <= '0;
      end
      if (nxt == CLR_ST) tick_count <= cnt_inc;
      // A stop seen outside RUN is remembered and honoured on the next RUN cycle.
      stop_pend <= (state == WR_CLR2) ? 1'b0 :
                   stop_pend | (cfg_stop && state != IDLE) | (nxt == CLR_ST && hit_max);
    end
`ifdef TIMER_CTRL_SNAP_EN
  // readdata lags the address by one cycle: low half arrives in SNAP_RDH, high in SNAP_DONE.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      snap_value <= '0;
      snap_valid <= 1'b0;
    end else begin
      if (state == SNAP_RDH) snap_value[15:0] <= m_readdata;
      if (state == SNAP_DONE) snap_value[31:16] <= m_readdata;
      snap_valid <= state == SNAP_DONE;
    end
`else
  logic unused;
  assign unused = ^m_readdata;
`endif
endmodule

// File: tb/tb_timer_ctrl_master.sv
// tb_timer_ctrl_master: table vectors, directed corner cases and random stimulus against a
// transaction-queue reference model, with a behavioural interval timer on the bus.
module tb_timer_ctrl_master;
  localparam int MT = 3;
  logic clk = 1'b0, reset_n = 1'b1;
  logic [31:0] cfg_period = '0;
  logic cfg_start = 1'b0, cfg_stop = 1'b0, frc = 1'b0;
  logic busy, tick;
  logic [15:0] tick_count;
  logic [2:0] m_address;
  logic m_chipselect, m_write_n;
  logic [15:0] m_writedata, m_readdata;
  logic irq_in;
`ifdef TIMER_CTRL_SNAP_EN
  logic [31:0] snap_value;
  logic snap_valid;
`endif
  timer_ctrl_master #(.TICK_W(16), .MAX_TICKS(MT)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_start(cfg_start),
    .cfg_stop(cfg_stop), .busy(busy), .tick(tick), .tick_count(tick_count),
`ifdef TIMER_CTRL_SNAP_EN
    .snap_value(snap_value), .snap_valid(snap_valid),
`endif
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .irq_in(irq_in)
  );
  always #5 clk = ~clk;

  // Behavioural interval timer slave (not reset by the DUT).
  logic [31:0] t_per = '0, t_cnt = '0, t_snap = '0;
  logic t_run = 1'b0, t_cont = 1'b0, t_ito = 1'b0, t_to = 1'b0;
  logic [15:0] t_rd = '0;
  assign m_readdata = t_rd;
  assign irq_in = (t_to & t_ito) | frc;
  always @(posedge clk) begin
    if (m_chipselect && !m_write_n) begin
      case (m_address)
        3'd0: t_to <= 1'b0;
        3'd1: begin
          t_ito <= m_writedata[0];
          t_cont <= m_writedata[1];
          if (m_writedata[2]) t_run <= 1'b1;
          else if (m_writedata[3]) t_run <= 1'b0;
        end
        3'd2: begin t_per[15:0] <= m_writedata; t_run <= 1'b0; end
        3'd3: begin t_per[31:16] <= m_writedata; t_run <= 1'b0; end
        3'd4: t_snap <= t_cnt;
        default: ;
      endcase
    end
    if (m_chipselect && m_write_n) t_rd <= (m_address == 3'd5) ? t_snap[31:16] : t_snap[15:0];
    if (!t_run) t_cnt <= t_per;
    else if (t_cnt == 0) begin
      t_to <= 1'b1;
      t_cnt <= t_per;
      if (!t_cont) t_run <= 1'b0;
    end else t_cnt <= t_cnt - 1;
  end

  // Reference model: a queue of bus operations still to be issued.
  typedef struct packed {
    logic [2:0] a;
    logic [15:0] d;
    logic w, tk, se, sd;
  } op_t;
  op_t q[$];
  op_t cur;
  bit cur_v = 0, active = 0, pend = 0, sv_exp = 0, chk_irq = 0, prev_tick = 0;
  logic [15:0] m_cnt = '0;
  int n_cmp = 0, n_bad = 0;

  function automatic op_t mk(input logic [2:0] a, input logic [15:0] d, input logic w,
                             input logic tk, input logic se, input logic sd);
    op_t o;
    o.a = a; o.d = d; o.w = w; o.tk = tk; o.se = se; o.sd = sd;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, 32'(act), 32'(exp));
  endtask

  task automatic m_reset();
    active = 0; pend = 0; cur_v = 0; sv_exp = 0; prev_tick = 0; m_cnt = '0;
    q.delete();
  endtask

  task automatic m_step(input bit st, input bit sp, input bit irq, input logic [31:0] p);
    bit was_v = cur_v;
    op_t was = cur;
    logic [31:0] pc;
    sv_exp = 0;
    cur_v = 0;
    if (active && sp) pend = 1;
    if (!active) begin
      if (st) begin
        pc = (p == 0) ? 32'd1 : p;
        active = 1;
        m_cnt = '0;
        q.push_back(mk(3'd2, pc[15:0], 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(3'd3, pc[31:16], 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(3'd1, 16'h0007, 1'b1, 1'b0, 1'b0, 1'b0));
      end
    end else if (q.size() == 0) begin
      if (was_v) begin
        if (was.se) begin active = 0; pend = 0; end
        sv_exp = was.sd;
      end else if (pend) begin
        q.push_back(mk(3'd1, 16'h0008, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(3'd0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0));
      end else if (irq) begin
        m_cnt++;
        if (MT != 0 && m_cnt == 16'(MT)) pend = 1;
        q.push_back(mk(3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0));
`ifdef TIMER_CTRL_SNAP_EN
        q.push_back(mk(3'd4, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(3'd4, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0));
        q.push_back(mk(3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1));
`endif
      end
    end
    if (q.size() != 0) begin cur = q.pop_front(); cur_v = 1; end
  endtask

  task automatic step(input bit st, input bit sp, input bit fi);
    bit irq_s;
    logic [31:0] p_s;
    @(negedge clk);
    cfg_start = st; cfg_stop = sp; frc = fi;
    #1 irq_s = irq_in;
    p_s = cfg_period;
    @(posedge clk);
    #1 cfg_start = 0; cfg_stop = 0; frc = 0;
    m_step(st, sp, irq_s, p_s);
    if (chk_irq && prev_tick) chkb("irq_low_after_tick", irq_in, 1'b0);
    prev_tick = cur_v && cur.tk;
    chkb("busy", busy, active);
    chkb("tick", tick, cur_v && cur.tk);
    chk("tick_count", 32'(tick_count), 32'(m_cnt));
    chkb("chipselect", m_chipselect, cur_v);
    chkb("write_n", m_write_n, !(cur_v && cur.w));
    if (cur_v) chk("address", 32'(m_address), 32'(cur.a));
    if (cur_v && cur.w) chk("writedata", 32'(m_writedata), 32'(cur.d));
`ifdef TIMER_CTRL_SNAP_EN
    chkb("snap_valid", snap_valid, sv_exp);
    if (sv_exp) begin
      chk("snap_value", snap_value, t_snap);
      chkb("snap_le_period", snap_value <= t_per, 1'b1);
    end
`endif
  endtask

  task automatic chk_reset_vals();
    chkb("rst_chipselect", m_chipselect, 1'b0);
    chkb("rst_write_n", m_write_n, 1'b1);
    chk("rst_address", 32'(m_address), 32'd0);
    chk("rst_writedata", 32'(m_writedata), 32'd0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_tick", tick, 1'b0);
    chk("rst_tick_count", 32'(tick_count), 32'd0);
`ifdef TIMER_CTRL_SNAP_EN
    chk("rst_snap_value", snap_value, 32'd0);
    chkb("rst_snap_valid", snap_valid, 1'b0);
`endif
  endtask

  task automatic mid_reset();
    #2 reset_n = 0;
    #1 chk_reset_vals();
    m_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  typedef struct {
    logic [31:0] p;
    logic [15:0] lo, hi;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int nt;
    bit tried, st;
    tbl[0] = '{32'h0001E847, 16'hE847, 16'h0001};
    tbl[1] = '{32'h00000000, 16'h0001, 16'h0000};
    tbl[2] = '{32'hFFFFFFFF, 16'hFFFF, 16'hFFFF};
    tbl[3] = '{32'h00010000, 16'h0000, 16'h0001};
    #1 reset_n = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset_n = 1;
    // Programming sequence, period clamp, and a restart request ignored while busy.
    for (int i = 0; i < 4; i++) begin
      cfg_period = tbl[i].p;
      step(1, 0, 0);
      chk("pl_addr", 32'(m_address), 32'd2);
      chk("pl_data", 32'(m_writedata), 32'(tbl[i].lo));
      chkb("busy_after_start", busy, 1'b1);
      cfg_period = 32'h5555AAAA;
      step(1, 0, 0);
      chk("ph_addr", 32'(m_address), 32'd3);
      chk("ph_data", 32'(m_writedata), 32'(tbl[i].hi));
      step(0, 0, 0);
      chk("ctrl_addr", 32'(m_address), 32'd1);
      chk("ctrl_data", 32'(m_writedata), 32'h7);
      step(0, 0, 0);
      chkb("run_bus_idle", m_chipselect, 1'b0);
      step(0, 1, 0);
      chk("stop_addr", 32'(m_address), 32'd1);
      chk("stop_data", 32'(m_writedata), 32'h8);
      step(0, 0, 0);
      chk("clr2_addr", 32'(m_address), 32'd0);
      chkb("clr2_write", m_write_n, 1'b0);
      step(0, 0, 0);
      chkb("idle_after_stop", busy, 1'b0);
    end
    // Stop coinciding with irq in RUN: stop wins, no tick.
    cfg_period = 32'h100;
    repeat (4) step(cfg_period == 32'h100 && !busy, 0, 0);
    step(0, 1, 1);
    chk("coinc_addr", 32'(m_address), 32'd1);
    chk("coinc_data", 32'(m_writedata), 32'h8);
    chkb("coinc_tick", tick, 1'b0);
    chk("coinc_count", 32'(tick_count), 32'd0);
    repeat (3) step(0, 0, 0);
    // Real timer, period 9, auto-stop after MT ticks; a restart after the first tick is ignored.
    chk_irq = 1;
    cfg_period = 32'd9;
    step(1, 0, 0);
    nt = 0;
    tried = 0;
    for (int i = 0; i < 80; i++) begin
      st = (nt == 1) && !tried;
      if (st) tried = 1;
      step(st, 0, 0);
      if (st) chk("no_restart_count", 32'(tick_count), 32'd1);
      if (tick) nt++;
    end
    chk("max_ticks_seen", nt, MT);
    chk("max_tick_count", 32'(tick_count), 32'(MT));
    chkb("max_busy", busy, 1'b0);
    repeat (5) begin
      step(0, 0, 0);
      chkb("no_write_after_stop", m_chipselect, 1'b0);
    end
    chk_irq = 0;
    // Reset in the middle of a programming sequence.
    cfg_period = 32'h1234;
    step(1, 0, 0);
    step(0, 0, 0);
    mid_reset();
    step(0, 0, 0);
    // Random stimulus.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0)
        cfg_period = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 20);
      step($urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0);
      if ($urandom_range(0, 399) == 0) mid_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
